axi4_burst_mem_slave: RTL
=========================

Name: axi4_burst_mem_slave

Overview:
- AXI4 full-protocol memory responder: the slave end of the burst traffic the AXI VIP master issues in the peripheral block designs.
- Accepts INCR/FIXED write and read bursts into a register-array memory and returns OKAY/SLVERR responses.
- Used as a self-contained burst target in BFM block designs. Also used as a scratch-memory slave behind the interconnect.
- Write and read channels run independently and concurrently.

Parameters:
- C_S_AXI_ID_WIDTH, 1, width of AWID/BID/ARID/RID.
- C_S_AXI_ADDR_WIDTH, 6, byte address width; memory depth = 2^(C_S_AXI_ADDR_WIDTH-2) 32-bit words (16 at default).
- Data width is fixed at 32 bits (4 byte lanes); not a parameter.

Ports:
- S_AXI_ACLK  in  1  clock; all logic on the rising edge.
- S_AXI_ARESETN  in  1  asynchronous, active-low reset.
- S_AXI_AWID  in  C_S_AXI_ID_WIDTH  write ID.
- S_AXI_AWADDR  in  C_S_AXI_ADDR_WIDTH  write start byte address.
- S_AXI_AWLEN  in  8  beats-1.
- S_AXI_AWSIZE  in  3  beat size.
- S_AXI_AWBURST  in  2  burst type.
- S_AXI_AWVALID / S_AXI_AWREADY  in/out  1  AW handshake.
- S_AXI_WDATA  in  32  write data.
- S_AXI_WSTRB  in  4  byte enables.
- S_AXI_WLAST  in  1  last write beat.
- S_AXI_WVALID / S_AXI_WREADY  in/out  1  W handshake.
- S_AXI_BID  out  C_S_AXI_ID_WIDTH  response ID.
- S_AXI_BRESP  out  2  write response.
- S_AXI_BVALID / S_AXI_BREADY  out/in  1  B handshake.
- S_AXI_ARID  in  C_S_AXI_ID_WIDTH  read ID.
- S_AXI_ARADDR  in  C_S_AXI_ADDR_WIDTH  read start byte address.
- S_AXI_ARLEN  in  8  beats-1.
- S_AXI_ARSIZE  in  3  beat size.
- S_AXI_ARBURST  in  2  burst type.
- S_AXI_ARVALID / S_AXI_ARREADY  in/out  1  AR handshake.
- S_AXI_RID  out  C_S_AXI_ID_WIDTH  read ID.
- S_AXI_RDATA  out  32  read data.
- S_AXI_RRESP  out  2  read response.
- S_AXI_RLAST  out  1  last read beat.
- S_AXI_RVALID / S_AXI_RREADY  out/in  1  R handshake.

Behaviour:
- Reset:
  - Both FSMs return to IDLE.
  - AWREADY=1 and ARREADY=1 (IDLE values).
  - WREADY, BVALID, RVALID, RLAST = 0; BRESP, RRESP, BID, RID, RDATA = 0.
  - Memory contents are not reset.
  - Reset mid-burst abandons the burst; beats already written stay written.
- Write FSM, W_IDLE -> W_DATA -> W_RESP:
  - W_IDLE: AWREADY=1. On AW handshake, latch ID, word address (AWADDR[ADDR_WIDTH-1:2]), LEN, burst type and error flag, then go to W_DATA. AWREADY drops the next cycle.
  - Error flag is set if AWSIZE!=2 or AWBURST is not FIXED(0) or INCR(1).
  - W_DATA: WREADY=1. Each W handshake writes the enabled byte lanes of WDATA at the current word (only if error flag=0), then increments the beat count.
  - Word address advances for INCR and holds for FIXED. Address wraps modulo depth, with no error.
  - On a handshake with WLAST=1, go to W_RESP.
  - If WLAST arrives with beat count != LEN, or beat count passes LEN without WLAST, set the error flag. Beats after LEN are not written; keep accepting until WLAST.
  - W_RESP: BVALID=1, BID=latched ID, BRESP = error ? SLVERR(2) : OKAY(0). Hold until BREADY, then go to W_IDLE (AWREADY=1 the next cycle).
  - Best case: B one cycle after the WLAST handshake.
- Read FSM, R_IDLE -> R_DATA:
  - R_IDLE: ARREADY=1. On AR handshake, latch fields and the error flag (same rules as write), then go to R_DATA.
  - RVALID=1 the cycle after the AR handshake, with RDATA = mem[start word], RID = latched ID, RLAST = (LEN==0).
  - RRESP = SLVERR with RDATA=0 on error, else OKAY.
  - R_DATA: RDATA/RRESP/RLAST are held stable while RVALID && !RREADY.
  - On RVALID && RREADY, the next beat is presented the following cycle with no bubble. Address update and wrap follow the write rules.
  - The handshake on the beat with RLAST=1 returns to R_IDLE, with RVALID=0 the next cycle.
- Concurrency:
  - Read and write use independent memory ports.
  - A read and a write to the same word in the same cycle: the read returns the old data; the new data is visible from the next beat.
- Outstanding transactions: exactly one read and one write. No interleaving, no reordering.

Test Plan:
- AWADDR=0, AWLEN=7, SIZE=2, INCR, WDATA 1..8, WSTRB=F -> BRESP=0, BID=AWID. Then ARADDR=0, ARLEN=7 -> RDATA 1..8, RLAST only on beat 8, RRESP=0.
- Write 0xFFFFFFFF to word 3, then write 0x12345678 with WSTRB=0101 to word 3 -> read returns 0xFF34FF78.
- AWADDR=0x38, AWLEN=3, data A,B,C,D -> words 14,15,0,1 hold A,B,C,D; a 4-beat read from 0x38 returns A,B,C,D.
- FIXED burst, AWADDR=0x10, LEN=3, data 5,6,7,8 -> word 4 = 8. AWSIZE=1 -> BRESP=2 and memory unchanged. ARBURST=2 -> four beats with RRESP=2, RDATA=0.
- Random RREADY/BREADY stalls (0-5 cycles) during an 8-beat read -> RDATA/RLAST stable during stalls, data in order, no beat lost or duplicated. RREADY held high -> 8 beats in 8 consecutive cycles.
- Assert ARESETN=0 after beat 3 of an 8-beat write -> BVALID=0, WREADY=0, AWREADY=1 after release; words 0-2 written; a new burst completes normally.

Source files
------------

// File: rtl/axi4_burst_mem_slave.sv
// AXI4 burst memory slave: independent write and read FSMs over a 32-bit register-array
// memory split into byte lanes, with INCR/FIXED bursts and OKAY/SLVERR responses.
module axi4_burst_mem_slave #(
  parameter int C_S_AXI_ID_WIDTH   = 1,
  parameter int C_S_AXI_ADDR_WIDTH = 6
) (
  input  logic                          S_AXI_ACLK,
  input  logic                          S_AXI_ARESETN,
  input  logic [C_S_AXI_ID_WIDTH-1:0]   S_AXI_AWID,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0] S_AXI_AWADDR,
  input  logic [7:0]                    S_AXI_AWLEN,
  input  logic [2:0]                    S_AXI_AWSIZE,
  input  logic [1:0]                    S_AXI_AWBURST,
  input  logic                          S_AXI_AWVALID,
  output logic                          S_AXI_AWREADY,
  input  logic [31:0]                   S_AXI_WDATA,
  input  logic [3:0]                    S_AXI_WSTRB,
  input  logic                          S_AXI_WLAST,
  input  logic                          S_AXI_WVALID,
  output logic                          S_AXI_WREADY,
  output logic [C_S_AXI_ID_WIDTH-1:0]   S_AXI_BID,
  output logic [1:0]                    S_AXI_BRESP,
  output logic                          S_AXI_BVALID,
  input  logic                          S_AXI_BREADY,
  input  logic [C_S_AXI_ID_WIDTH-1:0]   S_AXI_ARID,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0] S_AXI_ARADDR,
  input  logic [7:0]                    S_AXI_ARLEN,
  input  logic [2:0]                    S_AXI_ARSIZE,
  input  logic [1:0]                    S_AXI_ARBURST,
  input  logic                          S_AXI_ARVALID,
  output logic                          S_AXI_ARREADY,
  output logic [C_S_AXI_ID_WIDTH-1:0]   S_AXI_RID,
  output logic [31:0]                   S_AXI_RDATA,
  output logic [1:0]                    S_AXI_RRESP,
  output logic                          S_AXI_RLAST,
  output logic                          S_AXI_RVALID,
  input  logic                          S_AXI_RREADY
);

  localparam int WA    = C_S_AXI_ADDR_WIDTH - 2;
  localparam int DEPTH = 1 << WA;
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} wstate_t;
  typedef enum logic {R_IDLE, R_DATA} rstate_t;

  // ---------------- write channel ----------------
  wstate_t                     wstate_reg, wstate_next;
  logic [C_S_AXI_ID_WIDTH-1:0] awid_reg, awid_next;
  logic [WA-1:0]               waddr_reg, waddr_next;
  logic [7:0]                  wlen_reg, wlen_next;
  logic                        wfixed_reg, wfixed_next;
  logic                        werr_reg, werr_next;
  logic [8:0]                  wbeat_reg, wbeat_next;
  logic                        mem_we;

  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) begin
      wstate_reg <= W_IDLE;
      awid_reg   <= '0;
      waddr_reg  <= '0;
      wlen_reg   <= '0;
      wfixed_reg <= 1'b0;
      werr_reg   <= 1'b0;
      wbeat_reg  <= '0;
    end else begin
      wstate_reg <= wstate_next;
      awid_reg   <= awid_next;
      waddr_reg  <= waddr_next;
      wlen_reg   <= wlen_next;
      wfixed_reg <= wfixed_next;
      werr_reg   <= werr_next;
      wbeat_reg  <= wbeat_next;
    end
  end

  always_comb begin
    wstate_next = wstate_reg;
    awid_next   = awid_reg;
    waddr_next  = waddr_reg;
    wlen_next   = wlen_reg;
    wfixed_next = wfixed_reg;
    werr_next   = werr_reg;
    wbeat_next  = wbeat_reg;
    mem_we      = 1'b0;
    case (wstate_reg)
      W_IDLE: begin
        if (S_AXI_AWVALID) begin
          awid_next   = S_AXI_AWID;
          waddr_next  = S_AXI_AWADDR[C_S_AXI_ADDR_WIDTH-1:2];
          wlen_next   = S_AXI_AWLEN;
          wfixed_next = (S_AXI_AWBURST == 2'b00);
          werr_next   = (S_AXI_AWSIZE != 3'd2) || S_AXI_AWBURST[1];
          wbeat_next  = '0;
          wstate_next = W_DATA;
        end
      end
      W_DATA: begin
        if (S_AXI_WVALID) begin
          // Beats beyond LEN are absorbed without touching memory.
          mem_we     = !werr_reg && (wbeat_reg <= {1'b0, wlen_reg});
          wbeat_next = wbeat_reg + 9'd1;
          if (!wfixed_reg) waddr_next = waddr_reg + WA'(1);
          if (S_AXI_WLAST) begin
            if (wbeat_reg != {1'b0, wlen_reg}) werr_next = 1'b1;
            wstate_next = W_RESP;
          end else if (wbeat_reg >= {1'b0, wlen_reg}) begin
            werr_next = 1'b1;
          end
        end
      end
      W_RESP: begin
        if (S_AXI_BREADY) wstate_next = W_IDLE;
      end
      default: wstate_next = W_IDLE;
    endcase
  end

  assign S_AXI_AWREADY = (wstate_reg == W_IDLE);
  assign S_AXI_WREADY  = (wstate_reg == W_DATA);
  assign S_AXI_BVALID  = (wstate_reg == W_RESP);
  assign S_AXI_BID     = awid_reg;
  assign S_AXI_BRESP   = werr_reg ? RESP_SLVERR : RESP_OKAY;

  // ---------------- read channel ----------------
  rstate_t                     rstate_reg, rstate_next;
  logic [C_S_AXI_ID_WIDTH-1:0] rid_reg, rid_next;
  logic [WA-1:0]               raddr_reg, raddr_next;
  logic [7:0]                  rlen_reg, rlen_next;
  logic [7:0]                  rbeat_reg, rbeat_next;
  logic                        rfixed_reg, rfixed_next;
  logic                        rerr_reg, rerr_next;
  logic                        rlast_reg, rlast_next;
  logic                        rd_en;
  logic                        rd_zero;
  logic [WA-1:0]               rd_addr;

  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) begin
      rstate_reg <= R_IDLE;
      rid_reg    <= '0;
      raddr_reg  <= '0;
      rlen_reg   <= '0;
      rbeat_reg  <= '0;
      rfixed_reg <= 1'b0;
      rerr_reg   <= 1'b0;
      rlast_reg  <= 1'b0;
    end else begin
      rstate_reg <= rstate_next;
      rid_reg    <= rid_next;
      raddr_reg  <= raddr_next;
      rlen_reg   <= rlen_next;
      rbeat_reg  <= rbeat_next;
      rfixed_reg <= rfixed_next;
      rerr_reg   <= rerr_next;
      rlast_reg  <= rlast_next;
    end
  end

  always_comb begin
    rstate_next = rstate_reg;
    rid_next    = rid_reg;
    raddr_next  = raddr_reg;
    rlen_next   = rlen_reg;
    rbeat_next  = rbeat_reg;
    rfixed_next = rfixed_reg;
    rerr_next   = rerr_reg;
    rlast_next  = rlast_reg;
    rd_en       = 1'b0;
    rd_zero     = rerr_reg;
    rd_addr     = raddr_reg;
    case (rstate_reg)
      R_IDLE: begin
        if (S_AXI_ARVALID) begin
          rid_next    = S_AXI_ARID;
          raddr_next  = S_AXI_ARADDR[C_S_AXI_ADDR_WIDTH-1:2];
          rlen_next   = S_AXI_ARLEN;
          rbeat_next  = '0;
          rfixed_next = (S_AXI_ARBURST == 2'b00);
          rerr_next   = (S_AXI_ARSIZE != 3'd2) || S_AXI_ARBURST[1];
          rlast_next  = (S_AXI_ARLEN == 8'd0);
          rd_en       = 1'b1;
          rd_zero     = rerr_next;
          rd_addr     = raddr_next;
          rstate_next = R_DATA;
        end
      end
      R_DATA: begin
        if (S_AXI_RREADY) begin
          if (rlast_reg) begin
            rlast_next  = 1'b0;
            rstate_next = R_IDLE;
          end else begin
            // Fetch the following beat now so it is presented without a bubble.
            if (!rfixed_reg) raddr_next = raddr_reg + WA'(1);
            rbeat_next = rbeat_reg + 8'd1;
            rlast_next = ((rbeat_reg + 8'd1) == rlen_reg);
            rd_en      = 1'b1;
            rd_addr    = raddr_next;
          end
        end
      end
      default: rstate_next = R_IDLE;
    endcase
  end

  assign S_AXI_ARREADY = (rstate_reg == R_IDLE);
  assign S_AXI_RVALID  = (rstate_reg == R_DATA);
  assign S_AXI_RID     = rid_reg;
  assign S_AXI_RLAST   = rlast_reg;
  assign S_AXI_RRESP   = rerr_reg ? RESP_SLVERR : RESP_OKAY;

  // ---------------- memory: one array per byte lane ----------------
  logic [3:0][7:0] rdata_bytes;

  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_lane
      logic [7:0] mem_lane [DEPTH];
      logic [7:0] rd_byte_reg;

      always_ff @(posedge S_AXI_ACLK) begin
        if (mem_we && S_AXI_WSTRB[gi]) mem_lane[waddr_reg] <= S_AXI_WDATA[gi*8 +: 8];
      end

      // Registered read sees pre-write contents on a same-cycle collision.
      always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
        if (!S_AXI_ARESETN) rd_byte_reg <= 8'h00;
        else if (rd_en)     rd_byte_reg <= rd_zero ? 8'h00 : mem_lane[rd_addr];
      end

      assign rdata_bytes[gi] = rd_byte_reg;
    end
  endgenerate

  assign S_AXI_RDATA = rdata_bytes;

  logic unused_addr_lsbs;
  assign unused_addr_lsbs = ^{S_AXI_AWADDR[1:0], S_AXI_ARADDR[1:0]};

endmodule
